// File: rtl/panel_input_cond_pkg.sv
// Shared definitions for the front-panel input conditioner:
// key FSM state encoding and the default debounce length.
package panel_input_cond_pkg;

  // Default debounce length; synthesis builds override it.
  localparam int DB_CYCLES_DEFAULT = 4;

  // Key FSM states; 2'b11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    KEY_IDLE   = 2'b00,
    KEY_HELD   = 2'b01,
    KEY_REPEAT = 2'b10
  } key_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/panel_input_cond_debounce_bit.sv
// debounce_bit: 2-flop synchroniser followed by a debounce counter.
// Ports: clk, rst (async, active-high), din (raw), dout (debounced).
module debounce_bit
  import panel_input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only survives while the synced input disagrees
  // with the output; the DB_CYCLES-th disagreeing cycle flips it.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    out_d   = out_q;
    cnt_d   = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/panel_input_cond.sv
// panel_input_cond: conditions the raw front-panel key and switches.
// Inputs: clk, rst, A1_raw, SW_choose_raw, SW1_raw, SW2_raw, D_raw[7:0].
// Outputs: A1_level, step_pulse, SW_choose, SW1, SW2, D[7:0],
//          mode_change, key_state[1:0].
module panel_input_cond
  import panel_input_cond_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 8,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A1_raw,
  input  logic       SW_choose_raw,
  input  logic       SW1_raw,
  input  logic       SW2_raw,
  input  logic [7:0] D_raw,
  output logic       A1_level,
  output logic       step_pulse,
  output logic       SW_choose,
  output logic       SW1,
  output logic       SW2,
  output logic [7:0] D,
  output logic       mode_change,
  output logic [1:0] key_state
);

  localparam int TMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  // Polarity is normalised ahead of the synchroniser so that its
  // reset value of 0 already means "released"; a key held through
  // reset then travels the full sync + debounce path as a new press.
  logic a1_norm;
  assign a1_norm = KEY_ACTIVE_LOW ? ~A1_raw : A1_raw;

  debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_a1 (
    .clk  (clk),
    .rst  (rst),
    .din  (a1_norm),
    .dout (A1_level)
  );

  debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_sc (
    .clk  (clk),
    .rst  (rst),
    .din  (SW_choose_raw),
    .dout (SW_choose)
  );

  debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_sw1 (
    .clk  (clk),
    .rst  (rst),
    .din  (SW1_raw),
    .dout (SW1)
  );

  debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_sw2 (
    .clk  (clk),
    .rst  (rst),
    .din  (SW2_raw),
    .dout (SW2)
  );

  for (genvar i = 0; i < 8; i++) begin : g_d
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_d (
      .clk  (clk),
      .rst  (rst),
      .din  (D_raw[i]),
      .dout (D[i])
    );
  end

  // Mode change detection: compare against last cycle's levels.
  logic [2:0] mode_vec;
  logic [2:0] mode_prev_q, mode_prev_d;
  logic       mode_q, mode_d;

  assign mode_vec = {SW_choose, SW1, SW2};

  always_comb begin
    mode_prev_d = mode_vec;
    mode_d      = |(mode_vec ^ mode_prev_q);
  end

  // Key FSM.
  key_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_q, step_d;
  logic          a1_prev_q, a1_prev_d;
  logic          a1_rise;
  logic          expire;

  assign a1_prev_d = A1_level;
  assign a1_rise   = A1_level & ~a1_prev_q;
  assign expire    = (timer_q == T_ONE);

  // Release is tested first so it wins over a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    unique case (state_q)
      KEY_IDLE: begin
        timer_d = '0;
        if (a1_rise) begin
          state_d = KEY_HELD;
          timer_d = T_DELAY;
          step_d  = 1'b1;
        end
      end
      KEY_HELD: begin
        if (!A1_level) begin
          state_d = KEY_IDLE;
          timer_d = '0;
        end else if (REPEAT_EN && expire) begin
          state_d = KEY_REPEAT;
          timer_d = T_PERIOD;
          step_d  = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - T_ONE;
        end
      end
      KEY_REPEAT: begin
        if (!A1_level) begin
          state_d = KEY_IDLE;
          timer_d = '0;
        end else if (expire) begin
          timer_d = T_PERIOD;
          step_d  = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= KEY_IDLE;
      timer_q     <= '0;
      step_q      <= 1'b0;
      a1_prev_q   <= 1'b0;
      mode_prev_q <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
      a1_prev_q   <= a1_prev_d;
      mode_prev_q <= mode_prev_d;
      mode_q      <= mode_d;
    end
  end

  assign step_pulse  = step_q;
  assign mode_change = mode_q;
  assign key_state   = state_q;

endmodule
